// File: rtl/controller_responder.sv
// controller_responder
//   Device side of the serial game-controller protocol. Debounces raw
//   active-low buttons, snapshots them while the latch is high, and shifts
//   one button per rising controller_clk edge onto an active-low data line.
//
// Ports
//   clk               block clock, all state on rising edge
//   rst               asynchronous active-high reset
//   buttons_B         raw switch levels, 0 = pressed, asynchronous
//   controller_latch  latch from initiator, asynchronous
//   controller_clk    shift clock from initiator, asynchronous
//   data_out_B        serial data to initiator, 0 = pressed
//   buttons_debounced debounced button state, 1 = pressed
//   frame_done        one-cycle pulse after the last button is shifted
module controller_responder #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons_B,
  input  logic                   controller_latch,
  input  logic                   controller_clk,
  output logic                   data_out_B,
  output logic [NUM_BUTTONS-1:0] buttons_debounced,
  output logic                   frame_done
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BC_W  = $clog2(NUM_BUTTONS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BC_W-1:0]  BC_MAX   = BC_W'(NUM_BUTTONS);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NUM_BUTTONS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Synchronizer chains
  logic                   latch_s1_q, latch_s2_q;
  logic                   cclk_s1_q, cclk_s2_q, cclk_prev_q;
  logic [NUM_BUTTONS-1:0] btn_s1_q, btn_s2_q;

  // Debounce state
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]       db_cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       db_cnt_d [NUM_BUTTONS];

  // Frame state
  state_t                 state_q, state_d;
  logic [NUM_BUTTONS-1:0] sr_q, sr_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   frame_done_q, frame_done_d;

  logic                   clk_rise;
  logic [NUM_BUTTONS-1:0] raw_pressed;

  assign clk_rise          = cclk_s2_q & ~cclk_prev_q;
  assign raw_pressed       = ~btn_s2_q;
  assign buttons_debounced = stable_q;
  assign data_out_B        = ~sr_q[0];
  assign frame_done        = frame_done_q;

  // Button chains reset to released so no false press appears after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_s1_q  <= 1'b0;
      latch_s2_q  <= 1'b0;
      cclk_s1_q   <= 1'b0;
      cclk_s2_q   <= 1'b0;
      cclk_prev_q <= 1'b0;
      btn_s1_q    <= '1;
      btn_s2_q    <= '1;
    end else begin
      latch_s1_q  <= controller_latch;
      latch_s2_q  <= latch_s1_q;
      cclk_s1_q   <= controller_clk;
      cclk_s2_q   <= cclk_s1_q;
      cclk_prev_q <= cclk_s2_q;
      btn_s1_q    <= buttons_B;
      btn_s2_q    <= btn_s1_q;
    end
  end

  // A difference must persist DEBOUNCE_CYCLES consecutive cycles; any
  // cycle where raw agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (raw_pressed[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_LAST) begin
        stable_d[i] = raw_pressed[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Latch has priority over everything, including a coincident clk_rise.
  // Shifting in IDLE/DONE only moves zeros, so data_out_B idles at 1; only
  // a shift out of SHIFT can complete a frame.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (latch_s2_q) begin
      state_d   = S_LOAD;
      sr_d      = stable_q;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_SHIFT;
        end
        S_IDLE, S_SHIFT, S_DONE: begin
          if (clk_rise) begin
            sr_d = {1'b0, sr_q[NUM_BUTTONS-1:1]};
            if (bit_cnt_q != BC_MAX) begin
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
            if (state_q == S_SHIFT && bit_cnt_q == BC_LAST) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_controller_responder.sv
module tb_controller_responder;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] buttons_B;
  logic          controller_latch;
  logic          controller_clk;
  logic          data_out_B;
  logic [NB-1:0] buttons_debounced;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_total = 0;
  int fd_cyc   = 0;
  int rise_cyc = 0;

  controller_responder #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .buttons_B         (buttons_B),
    .controller_latch  (controller_latch),
    .controller_clk    (controller_clk),
    .data_out_B        (data_out_B),
    .buttons_debounced (buttons_debounced),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_total <= fd_total + 1;
      fd_cyc   <= cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the initiator sees ~pressed[i] for shift i, and 1 for
  // any shift beyond the last button.
  function automatic logic [15:0] model_serial(input logic [NB-1:0] pressed);
    logic [15:0] r;
    r = '1;
    for (int i = 0; i < NB; i++) r[i] = ~pressed[i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_latch();
    controller_latch = 1'b1;
    tick(4);
    controller_latch = 1'b0;
  endtask

  // Low phase of 4 cycles, sample data just before the rise, high phase of 4.
  task automatic do_clk(output logic d);
    tick(4);
    d = data_out_B;
    controller_clk = 1'b1;
    rise_cyc = cyc;
    tick(4);
    controller_clk = 1'b0;
  endtask

  task automatic test_reset();
    buttons_B = '1;
    controller_latch = 1'b0;
    controller_clk = 1'b0;
    rst = 1'b1;
    tick(3);
    checks++;
    if (data_out_B !== 1'b1) begin
      failures++; $display("FAIL reset_data got=%b exp=1", data_out_B);
    end
    checks++;
    if (buttons_debounced !== 8'h00) begin
      failures++; $display("FAIL reset_debounced got=%h exp=00", buttons_debounced);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done);
    end
    rst = 1'b0;
    tick(25);
    checks++;
    if (data_out_B !== 1'b1 || buttons_debounced !== 8'h00 || fd_total !== 0) begin
      failures++;
      $display("FAIL idle_released data=%b deb=%h fd=%0d exp data=1 deb=00 fd=0",
               data_out_B, buttons_debounced, fd_total);
    end
  endtask

  task automatic test_a_start();
    logic [15:0] got, exp;
    logic d;
    int f0;
    buttons_B = 8'hF6;
    tick(20);
    checks++;
    if (buttons_debounced !== 8'h09) begin
      failures++; $display("FAIL a_start_debounced got=%h exp=09", buttons_debounced);
    end
    exp = model_serial(8'h09);
    got = '1;
    f0 = fd_total;
    do_latch();
    for (int i = 0; i < NB; i++) begin
      do_clk(d);
      got[i] = d;
    end
    checks++;
    if (got[7:0] !== exp[7:0]) begin
      failures++; $display("FAIL a_start_frame got=%h exp=%h", got[7:0], exp[7:0]);
    end
    checks++;
    if ((fd_total - f0) !== 1 || (fd_cyc - rise_cyc) !== 3) begin
      failures++;
      $display("FAIL a_start_frame_done pulses=%0d delay=%0d exp pulses=1 delay=3",
               fd_total - f0, fd_cyc - rise_cyc);
    end
  endtask

  task automatic test_bounce();
    buttons_B = '1;
    tick(25);
    for (int t = 0; t < 60; t++) begin
      if (t % 5 == 0) buttons_B[0] = ~buttons_B[0];
      tick(1);
      checks++;
      if (buttons_debounced[0] !== 1'b0) begin
        failures++; $display("FAIL bounce_hold t=%0d got=%b exp=0", t, buttons_debounced[0]);
      end
    end
    buttons_B[0] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k >= 16) begin
        checks++;
        if (buttons_debounced[0] !== (k == 18)) begin
          failures++;
          $display("FAIL bounce_latency k=%0d got=%b exp=%b", k, buttons_debounced[0], k == 18);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [NB-1:0] p;
    logic [15:0] got, exp;
    logic d;
    int f0;
    for (int n = 0; n < 4; n++) begin
      p = NB'($urandom);
      buttons_B = ~p;
      tick(20);
      checks++;
      if (buttons_debounced !== p) begin
        failures++; $display("FAIL rand_debounced n=%0d got=%h exp=%h", n, buttons_debounced, p);
      end
      exp = model_serial(p);
      got = '1;
      f0 = fd_total;
      do_latch();
      for (int i = 0; i < NB; i++) begin
        do_clk(d);
        got[i] = d;
      end
      checks++;
      if (got[7:0] !== exp[7:0] || (fd_total - f0) !== 1) begin
        failures++;
        $display("FAIL rand_frame n=%0d got=%h exp=%h pulses=%0d exp_pulses=1",
                 n, got[7:0], exp[7:0], fd_total - f0);
      end
    end
  endtask

  task automatic test_latch_with_clk();
    logic [NB-1:0] p;
    logic [15:0] got, exp;
    logic d;
    int f0;
    p = NB'($urandom) | 8'h01;
    buttons_B = ~p;
    tick(20);
    f0 = fd_total;
    controller_latch = 1'b1;
    controller_clk = 1'b1;
    tick(4);
    controller_latch = 1'b0;
    tick(4);
    checks++;
    if (data_out_B !== ~p[0]) begin
      failures++; $display("FAIL latch_clk_bit0 got=%b exp=%b", data_out_B, ~p[0]);
    end
    controller_clk = 1'b0;
    exp = model_serial(p);
    got = '1;
    for (int i = 0; i < 10; i++) begin
      do_clk(d);
      got[i] = d;
      if (i == 7) begin
        checks++;
        if ((fd_total - f0) !== 1 || (fd_cyc - rise_cyc) !== 3) begin
          failures++;
          $display("FAIL latch_clk_frame_done pulses=%0d delay=%0d exp pulses=1 delay=3",
                   fd_total - f0, fd_cyc - rise_cyc);
        end
      end
    end
    checks++;
    if (got[9:0] !== exp[9:0]) begin
      failures++; $display("FAIL latch_clk_frame got=%h exp=%h", got[9:0], exp[9:0]);
    end
    tick(4);
    checks++;
    if (data_out_B !== 1'b1 || (fd_total - f0) !== 1) begin
      failures++;
      $display("FAIL after_done data=%b pulses=%0d exp data=1 pulses=1", data_out_B, fd_total - f0);
    end
  endtask

  task automatic test_midframe_change();
    logic [NB-1:0] p, q;
    logic [15:0] got, exp;
    logic d;
    p = NB'($urandom);
    q = ~p;
    buttons_B = ~p;
    tick(20);
    exp = model_serial(p);
    got = '1;
    do_latch();
    for (int i = 0; i < NB; i++) begin
      if (i == 3) buttons_B = ~q;
      do_clk(d);
      got[i] = d;
    end
    checks++;
    if (got[7:0] !== exp[7:0]) begin
      failures++; $display("FAIL midframe_snapshot got=%h exp=%h", got[7:0], exp[7:0]);
    end
    tick(20);
    checks++;
    if (buttons_debounced !== q) begin
      failures++; $display("FAIL midframe_debounced got=%h exp=%h", buttons_debounced, q);
    end
    exp = model_serial(q);
    got = '1;
    do_latch();
    for (int i = 0; i < NB; i++) begin
      do_clk(d);
      got[i] = d;
    end
    checks++;
    if (got[7:0] !== exp[7:0]) begin
      failures++; $display("FAIL midframe_next got=%h exp=%h", got[7:0], exp[7:0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [NB-1:0] p;
    logic [15:0] got, exp;
    logic d;
    int f0;
    p = NB'($urandom) | 8'h10;
    buttons_B = ~p;
    tick(20);
    do_latch();
    for (int i = 0; i < 4; i++) do_clk(d);
    tick(4);
    checks++;
    if (data_out_B !== 1'b0) begin
      failures++; $display("FAIL pre_reset_bit4 got=%b exp=0", data_out_B);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (data_out_B !== 1'b1) begin
      failures++; $display("FAIL async_reset_data got=%b exp=1", data_out_B);
    end
    tick(2);
    checks++;
    if (buttons_debounced !== 8'h00 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midframe_state deb=%h fd=%b exp deb=00 fd=0", buttons_debounced, frame_done);
    end
    rst = 1'b0;
    tick(20);
    exp = model_serial(p);
    got = '1;
    f0 = fd_total;
    do_latch();
    for (int i = 0; i < NB; i++) begin
      do_clk(d);
      got[i] = d;
    end
    checks++;
    if (got[7:0] !== exp[7:0] || (fd_total - f0) !== 1) begin
      failures++;
      $display("FAIL post_reset_frame got=%h exp=%h pulses=%0d exp_pulses=1",
               got[7:0], exp[7:0], fd_total - f0);
    end
  endtask

  initial begin
    test_reset();
    test_a_start();
    test_bounce();
    test_random_frames();
    test_latch_with_clk();
    test_midframe_change();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
